pipelined_rca: RTL
==================

Name: pipelined_rca

Overview:
Parametrised, pipelined signed ripple-carry adder for the FIR accumulate path. The adder splits WIDTH into NSEG = WIDTH/SEG_W segments and registers the carry between segments, one segment per stage, so timing closes at wide accumulator widths. It has a valid/ready stream interface, signed-overflow detection and optional saturation. It replaces fixed-width combinational adders wherever the accumulator is registered.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG_W.
SEG_W, 8, bits resolved per pipeline stage; latency = WIDTH/SEG_W cycles.
SATURATE, 0, 1 = clamp signed overflow to the most-positive or most-negative value; 0 = wrap.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  adder accepts a beat this cycle
a  in  WIDTH  signed operand A
b  in  WIDTH  signed operand B
cin  in  1  carry-in to bit 0
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
sum  out  WIDTH  signed result, wrapped or saturated
carry  out  1  unsigned carry-out of the MSB
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, sum=0, carry=0, ovf=0. All stage valid bits, carries and partial sums are cleared. in_ready=1 the cycle after rst deasserts.
- Pipeline: NSEG stages. Stage k (0..NSEG-1) adds segment k of a and b plus the registered carry from stage k-1. Stage 0 uses cin.
- Operand skew: a/b segments above k travel with the beat in delay registers, so segment k is added exactly at stage k.
- Result deskew: lower result segments are held with the beat, so sum is presented complete, never partial.
- Latency is NSEG cycles from input acceptance to out_valid (2 at defaults). Throughput is one beat per cycle when not stalled.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - When advance=0, every stage holds its contents, including bubbles.
  - out_valid, sum, carry and ovf stay stable while out_valid & !out_ready.
- Bubbles: an in_valid=0 cycle with advance=1 inserts an invalid slot. Slots are never reordered or merged.
- Final stage arithmetic:
  - carry = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry.
- Saturation (SATURATE=1) when ovf=1:
  - sum = 2^(WIDTH-1)-1 if a[MSB]=b[MSB]=0.
  - sum = -2^(WIDTH-1) if a[MSB]=b[MSB]=1.
  - carry and ovf are reported unmodified.
- Boundaries:
  - NSEG=1 degenerates to a single registered adder with latency 1.
  - A full pipeline with out_ready=0 deasserts in_ready the same cycle; no beat is dropped or overwritten.
  - rst asserted mid-stream discards all in-flight beats immediately (asynchronous). No result for those beats ever appears.
- Elaboration: WIDTH % SEG_W != 0 or SEG_W < 1 raises an elaboration-time error.

Decomposition:
- Shared package fir_arith_pkg holds the NSEG computation function, the saturation max/min constants as functions of WIDTH, and the parameter legality check.
- One sub-module: rca_segment. It is a combinational SEG_W-bit ripple adder with ports a, b, ci, s, co, and additionally co_msb_in (carry into its top bit), used by the last stage for ovf.
- pipelined_rca instantiates NSEG rca_segment instances via generate, plus the stage/skew registers and the handshake logic.

Test Plan:
- Defaults, a=0x00FF, b=0x0001, cin=0, out_ready=1 -> two cycles later out_valid=1, sum=0x0100, carry=0, ovf=0; checks the inter-stage carry.
- a=0x7FFF, b=0x0001, cin=0 -> SATURATE=0: sum=0x8000, ovf=1, carry=0; SATURATE=1: sum=0x7FFF, ovf=1.
- a=0x8000, b=0x8000, SATURATE=1 -> sum=0x8000, carry=1, ovf=1. a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1, ovf=0.
- Stream 0x0001+0x0001, 0x0010+0x0010, 0x0100+0x0100, 0x1000+0x1000 back-to-back, out_ready=0 on cycles 2-3 -> in_ready drops while full. Outputs are 0x0002, 0x0020, 0x0200, 0x2000 in order, stable during the stall, none lost.
- Two beats in flight, rst pulsed mid-cycle -> out_valid=0 and sum=0 immediately. No stale result appears after release; a new beat 0x0003+0x0004 returns 0x0007 after 2 cycles.
- WIDTH=32, SEG_W=8, a=0x00FFFFFF, b=0x00000001, cin=0 -> sum=0x01000000 after 4 cycles, carry=0; checks the carry propagating across three stage boundaries.

Source files
------------

// File: rtl/fir_arith_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fir_arith_pkg                                              |
// | Description : Shared arithmetic helpers for the FIR accumulate path:     |
// |               pipeline segment count, signed saturation limits and the   |
// |               WIDTH/SEG_W legality check.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fir_arith_pkg;

  // Widest operand the saturation helpers can describe.
  localparam int MAX_W = 128;

  // WIDTH must be a positive whole number of SEG_W-bit segments.
  function automatic bit params_legal(input int width, input int seg_w);
    if (seg_w < 1 || width < 1) return 1'b0;
    return (width % seg_w) == 0;
  endfunction

  // Number of pipeline stages; guarded so an illegal SEG_W never divides by 0.
  function automatic int nseg(input int width, input int seg_w);
    if (seg_w < 1) return 1;
    return width / seg_w;
  endfunction

  // Most-positive signed value of the given width: 2^(width-1)-1.
  function automatic logic [MAX_W-1:0] sat_max(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Most-negative signed value of the given width: -2^(width-1).
  function automatic logic [MAX_W-1:0] sat_min(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_segment.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rca_segment                                                |
// | Description : Combinational SEG_W-bit ripple-carry adder slice.          |
// | Ports       : a, b      - segment operands                               |
// |               ci        - carry into bit 0                               |
// |               s         - segment sum                                    |
// |               co        - carry out of the top bit                       |
// |               co_msb_in - carry into the top bit (signed overflow term)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rca_segment
  import fir_arith_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             co_msb_in
);

  // c[i] is the carry into bit i; c[SEG_W] is the carry out of the slice.
  logic [SEG_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co        = c[SEG_W];
  assign co_msb_in = c[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_rca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipelined_rca                                              |
// | Description : Pipelined signed ripple-carry adder. One SEG_W segment is  |
// |               resolved per stage with the carry registered between       |
// |               stages; valid/ready stream interface, signed overflow      |
// |               flag and optional saturation. Latency WIDTH/SEG_W cycles.  |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid/in_ready, a, b, cin   - operand beat             |
// |               out_valid/out_ready, sum, carry, ovf - result beat         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipelined_rca
  import fir_arith_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SEG_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  if (!params_legal(WIDTH, SEG_W)) begin : g_param_check
    $error("pipelined_rca: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
           WIDTH, SEG_W);
  end

  // Rank k holds the beat after stage k. s_q[k] carries the finished sum
  // segments 0..k in its low bits and the still-unconsumed A segments above,
  // so one vector both skews A and deskews the result. b_q[k] carries B.
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  c_q;
  logic             ovf_q;

  // Stage inputs and next-state values.
  logic [WIDTH-1:0] op_s  [NSEG];
  logic [WIDTH-1:0] op_b  [NSEG];
  logic [WIDTH-1:0] s_nxt [NSEG];
  logic [SEG_W-1:0] seg_s [NSEG];
  logic [NSEG-1:0]  op_c;
  logic [NSEG-1:0]  op_v;
  logic [NSEG-1:0]  co_w;
  logic [NSEG-1:0]  msb_w;
  logic [NSEG-1:0]  unused_w;
  logic             advance;
  logic             ovf_w;

  // Whole pipeline moves in lockstep; a full, stalled output freezes it.
  assign advance  = !v_q[NSEG-1] | out_ready;
  assign in_ready = advance;

  assign ovf_w = msb_w[NSEG-1] ^ co_w[NSEG-1];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign op_s[k] = a;
      assign op_b[k] = b;
      assign op_c[k] = cin;
      assign op_v[k] = in_valid;
    end else begin : g_body
      assign op_s[k] = s_q[k-1];
      assign op_b[k] = b_q[k-1];
      assign op_c[k] = c_q[k-1];
      assign op_v[k] = v_q[k-1];
    end

    rca_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a         (op_s[k][k*SEG_W +: SEG_W]),
      .b         (op_b[k][k*SEG_W +: SEG_W]),
      .ci        (op_c[k]),
      .s         (seg_s[k]),
      .co        (co_w[k]),
      .co_msb_in (msb_w[k])
    );

    // Replace A segment k with its sum; everything else rides along.
    logic [WIDTH-1:0] merged;
    always_comb begin
      merged                     = op_s[k];
      merged[k*SEG_W +: SEG_W]   = seg_s[k];
    end

    if (k == NSEG-1 && SATURATE != 0) begin : g_sat
      // Overflow only occurs when both operand signs agree, so A's MSB
      // (still unconsumed in op_s at the last stage) picks the limit.
      assign s_nxt[k] = ovf_w ? (op_s[k][WIDTH-1] ? SAT_MIN : SAT_MAX) : merged;
    end else begin : g_wrap
      assign s_nxt[k] = merged;
    end

    // B bits below the active segment and the per-slice top-bit carries of
    // the inner stages are deliberately dropped.
    assign unused_w[k] = ^{b_q[k], msb_w[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        s_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= op_v;
      c_q   <= co_w;
      ovf_q <= ovf_w;
      for (int k = 0; k < NSEG; k++) begin
        s_q[k] <= s_nxt[k];
        b_q[k] <= op_b[k];
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign carry     = c_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
